// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock divider, raster counters and registered sync/visible decode.
// Optional frame counter output is enabled by defining VGA_FRAMECNT_EN.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic             pixEn,
  output logic             hSync,
  output logic             vSync,
  output logic             bright,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic [CNT_W-1:0] pixX,
  output logic [CNT_W-1:0] pixY,
  output logic             lineStart,
`ifdef VGA_FRAMECNT_EN
  output logic             frameStart,
  output logic [7:0]       frameCount
`else
  output logic             frameStart
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HA0      = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] VA0      = CNT_W'(V_SYNC + V_BP);

  // Region bounds carry one extra bit so an active area ending exactly at 2^CNT_W still compares correctly
  localparam logic [CNT_W:0] H_SYNC_X = (CNT_W+1)'(H_SYNC);
  localparam logic [CNT_W:0] V_SYNC_X = (CNT_W+1)'(V_SYNC);
  localparam logic [CNT_W:0] HA0_X    = (CNT_W+1)'(H_SYNC + H_BP);
  localparam logic [CNT_W:0] VA0_X    = (CNT_W+1)'(V_SYNC + V_BP);
  localparam logic [CNT_W:0] HA_END_X = (CNT_W+1)'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W:0] VA_END_X = (CNT_W+1)'(V_SYNC + V_BP + V_ACTIVE);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] pix_x_q, pix_x_d;
  logic [CNT_W-1:0] pix_y_q, pix_y_d;
  logic             pix_en_q, pix_en_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             bright_q, bright_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic [CNT_W:0]   h_ext, v_ext;
  logic             step, h_act, v_act;
`ifdef VGA_FRAMECNT_EN
  logic [7:0]       frame_cnt_q, frame_cnt_d;
`endif

  // Next-state counters; every output is decoded from them so the registered outputs all describe one position
  always_comb begin
    step          = (div_cnt_q == DIV_LAST);
    div_cnt_d     = step ? '0 : div_cnt_q + DIV_W'(1);
    pix_en_d      = step;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (step) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d      = '0;
        line_start_d = 1'b1;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d       = '0;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + CNT_W'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end

    h_ext    = {1'b0, h_cnt_d};
    v_ext    = {1'b0, v_cnt_d};
    hsync_d  = (h_ext < H_SYNC_X) ? HS_POL : ~HS_POL;
    vsync_d  = (v_ext < V_SYNC_X) ? VS_POL : ~VS_POL;
    h_act    = (h_ext >= HA0_X) && (h_ext < HA_END_X);
    v_act    = (v_ext >= VA0_X) && (v_ext < VA_END_X);
    bright_d = h_act && v_act;
    pix_x_d  = bright_d ? (h_cnt_d - HA0) : '0;
    pix_y_d  = bright_d ? (v_cnt_d - VA0) : '0;
`ifdef VGA_FRAMECNT_EN
    frame_cnt_d = frame_start_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_en_q      <= 1'b0;
      hsync_q       <= HS_POL;
      vsync_q       <= VS_POL;
      bright_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VGA_FRAMECNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_en_q      <= pix_en_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      bright_q      <= bright_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_FRAMECNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  assign pixEn      = pix_en_q;
  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign bright     = bright_q;
  assign hCount     = h_cnt_q;
  assign vCount     = v_cnt_q;
  assign pixX       = pix_x_q;
  assign pixY       = pix_y_q;
  assign lineStart  = line_start_q;
  assign frameStart = frame_start_q;
`ifdef VGA_FRAMECNT_EN
  assign frameCount = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three configurations checked against an arithmetic raster model.
// Frame counter checks are compiled in when VGA_FRAMECNT_EN is defined.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic rst_def = 1'b1, rst_sml = 1'b1, rst_med = 1'b1;

  logic pe_def, hs_def, vs_def, br_def, ls_def, fs_def;
  logic pe_sml, hs_sml, vs_sml, br_sml, ls_sml, fs_sml;
  logic pe_med, hs_med, vs_med, br_med, ls_med, fs_med;
  logic [9:0] h_def, v_def, x_def, y_def;
  logic [9:0] h_sml, v_sml, x_sml, y_sml;
  logic [9:0] h_med, v_med, x_med, y_med;
`ifdef VGA_FRAMECNT_EN
  logic [7:0] fc_def, fc_sml, fc_med;
`endif

  vga_timing_gen dut_def (
    .Clk(clk), .Reset(rst_def), .pixEn(pe_def), .hSync(hs_def), .vSync(vs_def),
    .bright(br_def), .hCount(h_def), .vCount(v_def), .pixX(x_def), .pixY(y_def),
    .lineStart(ls_def), .frameStart(fs_def)
`ifdef VGA_FRAMECNT_EN
    , .frameCount(fc_def)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(10)
  ) dut_sml (
    .Clk(clk), .Reset(rst_sml), .pixEn(pe_sml), .hSync(hs_sml), .vSync(vs_sml),
    .bright(br_sml), .hCount(h_sml), .vCount(v_sml), .pixX(x_sml), .pixY(y_sml),
    .lineStart(ls_sml), .frameStart(fs_sml)
`ifdef VGA_FRAMECNT_EN
    , .frameCount(fc_sml)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_SYNC(8), .H_BP(4), .H_ACTIVE(20), .H_FP(4),
    .V_SYNC(2), .V_BP(3), .V_ACTIVE(15), .V_FP(2), .HS_POL(1'b1), .VS_POL(1'b0), .CNT_W(10)
  ) dut_med (
    .Clk(clk), .Reset(rst_med), .pixEn(pe_med), .hSync(hs_med), .vSync(vs_med),
    .bright(br_med), .hCount(h_med), .vCount(v_med), .pixX(x_med), .pixY(y_med),
    .lineStart(ls_med), .frameStart(fs_med)
`ifdef VGA_FRAMECNT_EN
    , .frameCount(fc_med)
`endif
  );

  logic [45:0] act_def, act_sml, act_med;
  assign act_def = {pe_def, hs_def, vs_def, br_def, h_def, v_def, x_def, y_def, ls_def, fs_def};
  assign act_sml = {pe_sml, hs_sml, vs_sml, br_sml, h_sml, v_sml, x_sml, y_sml, ls_sml, fs_sml};
  assign act_med = {pe_med, hs_med, vs_med, br_med, h_med, v_med, x_med, y_med, ls_med, fs_med};

  localparam logic [45:0] RST_DEF = {1'b0, 1'b0, 1'b0, 1'b0, 40'd0, 2'b00};
  localparam logic [45:0] RST_SML = {1'b0, 1'b1, 1'b1, 1'b0, 40'd0, 2'b00};
  localparam logic [45:0] RST_MED = {1'b0, 1'b1, 1'b0, 1'b0, 40'd0, 2'b00};

  // Clocks elapsed since the last edge that saw Reset high
  int c_def = 0, c_sml = 0, c_med = 0;
  always @(posedge clk) begin
    c_def <= rst_def ? 0 : c_def + 1;
    c_sml <= rst_sml ? 0 : c_sml + 1;
    c_med <= rst_med ? 0 : c_med + 1;
  end

  // Position follows directly from the number of pixel steps since reset
  function automatic logic [45:0] model_out(input int c, input int dv,
      input int hs, input int hbp, input int ha, input int hfp,
      input int vs, input int vbp, input int va, input int vfp, input bit hp, input bit vp);
    int ht, vt, steps, h, v, x, y;
    bit pe, br;
    ht    = hs + hbp + ha + hfp;
    vt    = vs + vbp + va + vfp;
    pe    = (c > 0) && (c % dv == 0);
    steps = c / dv;
    h     = steps % ht;
    v     = (steps / ht) % vt;
    br    = (h >= hs + hbp) && (h < hs + hbp + ha) && (v >= vs + vbp) && (v < vs + vbp + va);
    x     = br ? h - hs - hbp : 0;
    y     = br ? v - vs - vbp : 0;
    return {pe, (h < hs) ? hp : ~hp, (v < vs) ? vp : ~vp, br, 10'(h), 10'(v), 10'(x), 10'(y),
            pe && (h == 0), pe && (h == 0) && (v == 0)};
  endfunction

  function automatic logic [45:0] exp_def(input int c);
    return model_out(c, 4, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0, 1'b0);
  endfunction
  function automatic logic [45:0] exp_sml(input int c);
    return model_out(c, 1, 2, 1, 4, 1, 1, 1, 3, 1, 1'b1, 1'b1);
  endfunction
  function automatic logic [45:0] exp_med(input int c);
    return model_out(c, 3, 8, 4, 20, 4, 2, 3, 15, 2, 1'b1, 1'b0);
  endfunction
  function automatic logic [7:0] exp_fc(input int c, input int dv, input int frame_len);
    return 8'(((c / dv) / frame_len) % 256);
  endfunction

  task test_reset;
    @(negedge clk);
    rst_def = 1'b1; rst_sml = 1'b1; rst_med = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (act_def !== RST_DEF) begin
      failures++; $display("[TB] FAIL reset_def actual=%h required=%h", act_def, RST_DEF);
    end
    checks++;
    if (act_sml !== RST_SML) begin
      failures++; $display("[TB] FAIL reset_sml actual=%h required=%h", act_sml, RST_SML);
    end
    checks++;
    if (act_med !== RST_MED) begin
      failures++; $display("[TB] FAIL reset_med actual=%h required=%h", act_med, RST_MED);
    end
  endtask

  task test_default_line;
    int n, cyc, last_ls, ls_cnt, max_h;
    logic [45:0] e;
    n = 0; last_ls = -1; ls_cnt = 0; max_h = 0; cyc = 0;
    rst_def = 1'b0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(posedge clk); #1;
      if (pe_def) n = i;
    end
    checks++;
    if (n != 4) begin
      failures++; $display("[TB] FAIL first_pixen_clk actual=%0d required=4", n);
    end
    repeat (2 * 3200 + 50) begin
      @(negedge clk);
      cyc++;
      e = exp_def(c_def);
      checks++;
      if (act_def !== e) begin
        failures++; $display("[TB] FAIL def_raster c=%0d actual=%h required=%h", c_def, act_def, e);
      end
      if (int'(h_def) > max_h) max_h = int'(h_def);
      if (ls_def === 1'b1) begin
        ls_cnt++;
        if (last_ls >= 0) begin
          checks++;
          if (cyc - last_ls != 3200) begin
            failures++; $display("[TB] FAIL line_period actual=%0d required=3200", cyc - last_ls);
          end
        end
        last_ls = cyc;
      end
    end
    checks++;
    if (max_h != 799) begin
      failures++; $display("[TB] FAIL h_total_max actual=%0d required=799", max_h);
    end
    checks++;
    if (ls_cnt != 2) begin
      failures++; $display("[TB] FAIL line_start_count actual=%0d required=2", ls_cnt);
    end
  endtask

  task test_small_frame;
    int cyc, last_fs, fs_cnt, br_cnt;
    logic [45:0] e;
    cyc = 0; last_fs = -1; fs_cnt = 0; br_cnt = 0;
    rst_sml = 1'b0;
    repeat (3 * 48 + 5) begin
      @(negedge clk);
      cyc++;
      e = exp_sml(c_sml);
      checks++;
      if (act_sml !== e) begin
        failures++; $display("[TB] FAIL sml_raster c=%0d actual=%h required=%h", c_sml, act_sml, e);
      end
      if (fs_sml === 1'b1) begin
        fs_cnt++;
        if (last_fs >= 0) begin
          checks++;
          if (cyc - last_fs != 48) begin
            failures++; $display("[TB] FAIL frame_period actual=%0d required=48", cyc - last_fs);
          end
        end
        last_fs = cyc;
      end
      if (fs_cnt == 1 && br_sml === 1'b1) br_cnt++;
    end
    checks++;
    if (fs_cnt != 3) begin
      failures++; $display("[TB] FAIL frame_start_count actual=%0d required=3", fs_cnt);
    end
    checks++;
    if (br_cnt != 12) begin
      failures++; $display("[TB] FAIL bright_per_frame actual=%0d required=12", br_cnt);
    end
  endtask

  task test_random_reset;
    int hold;
    logic [45:0] e;
    hold = 0;
    rst_med = 1'b0;
    repeat (3000) begin
      @(negedge clk);
      e = exp_med(c_med);
      checks++;
      if (act_med !== e) begin
        failures++; $display("[TB] FAIL med_raster c=%0d rst=%0b actual=%h required=%h", c_med, rst_med, act_med, e);
      end
`ifdef VGA_FRAMECNT_EN
      checks++;
      if (fc_med !== exp_fc(c_med, 3, 36 * 22)) begin
        failures++; $display("[TB] FAIL med_frame_count actual=%0d required=%0d", fc_med, exp_fc(c_med, 3, 36 * 22));
      end
`endif
      if (rst_med) begin
        if (hold == 0) rst_med = 1'b0;
        else hold--;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_med = 1'b1;
        hold = int'($urandom_range(0, 2));
      end
    end
    rst_med = 1'b0;
    @(negedge clk);
  endtask

  task test_mid_frame_reset;
    bit found;
    logic [45:0] e;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (h_med == 10'd18 && v_med == 10'd10) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++; $display("[TB] FAIL mid_frame_wait actual=timeout required=h18_v10");
    end else begin
      rst_med = 1'b1;
      @(negedge clk);
      checks++;
      if (act_med !== RST_MED) begin
        failures++; $display("[TB] FAIL mid_frame_reset actual=%h required=%h", act_med, RST_MED);
      end
      rst_med = 1'b0;
      repeat (36 * 3 + 5) begin
        @(negedge clk);
        e = exp_med(c_med);
        checks++;
        if (act_med !== e) begin
          failures++; $display("[TB] FAIL post_reset_line c=%0d actual=%h required=%h", c_med, act_med, e);
        end
      end
    end
  endtask

`ifdef VGA_FRAMECNT_EN
  task test_frame_count;
    int fs_cnt;
    fs_cnt = 0;
    @(negedge clk);
    rst_sml = 1'b1;
    @(negedge clk);
    rst_sml = 1'b0;
    for (int i = 0; i < 257 * 48 + 100 && fs_cnt < 257; i++) begin
      @(negedge clk);
      if (fs_sml === 1'b1) fs_cnt++;
    end
    checks++;
    if (fs_cnt != 257) begin
      failures++; $display("[TB] FAIL frame_start_257 actual=%0d required=257", fs_cnt);
    end else begin
      checks++;
      if (fc_sml !== 8'd1) begin
        failures++; $display("[TB] FAIL frame_count_wrap actual=%0d required=1", fc_sml);
      end
    end
    rst_sml = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (fc_sml !== 8'd0) begin
        failures++; $display("[TB] FAIL frame_count_reset actual=%0d required=0", fc_sml);
      end
    end
    rst_sml = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_default_line();
    test_small_frame();
    test_random_reset();
    test_mid_frame_reset();
`ifdef VGA_FRAMECNT_EN
    test_frame_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
